cell_move_decoder: RTL and testbench

Parametrised, registered successor to the combinational cell-select decoder. Accepts a move request (cell index) over a valid/ready handshake and checks it against range and an internal occupancy mask. A legal move produces a one-cycle one-hot write-enable strobe to the addressed board cell and flips the current player. Sits between the input/cursor logic and the board cell registers of the tic-tac-toe datapath; generalises to N×N boards.

---
 rtl/cell_move_decoder.sv | 150 +++++++++++++++
 tb/tb_cell_move_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_move_decoder.sv
// Registered move decoder: checks a requested cell against range and occupancy,
// then emits a one-hot write strobe. Optional move counter under MOVE_COUNT_EN.
module cell_move_decoder #(
   parameter int N_CELLS = 9,
   parameter int SEL_W   = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               move_valid,
   input  logic [SEL_W-1:0]   move_sel,
   output logic               move_ready,
   output logic [N_CELLS-1:0] en,
   output logic               player,
   output logic               ack,
   output logic               reject,
   output logic [1:0]         err_code,
   output logic [N_CELLS-1:0] occupied,
   output logic               board_full
`ifdef MOVE_COUNT_EN
  ,output logic [$clog2(N_CELLS+1)-1:0] move_count
`endif
);

   typedef enum logic [1:0] {IDLE, CHECK, RESULT} state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_RANGE = 2'b01;
   localparam logic [1:0] ERR_OCC   = 2'b10;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [N_CELLS-1:0] en_q, en_d;
   logic [N_CELLS-1:0] occ_q, occ_d;
   logic               player_q, player_d;
   logic               ack_q, ack_d;
   logic               reject_q, reject_d;
   logic [1:0]         err_q, err_d;
   logic               full_q, full_d;
   logic [N_CELLS-1:0] onehot;

`ifdef MOVE_COUNT_EN
   localparam int CNT_W = $clog2(N_CELLS+1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // An index at or beyond N_CELLS decodes to all-zero, which doubles as the range check.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_CELLS; i++)
         if (sel_q == SEL_W'(i)) onehot[i] = 1'b1;
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      en_d     = '0;
      ack_d    = 1'b0;
      reject_d = 1'b0;
      err_d    = err_q;
      occ_d    = occ_q;
      player_d = player_q;
`ifdef MOVE_COUNT_EN
      cnt_d    = cnt_q;
`endif
      if (clear) begin
         state_d  = IDLE;
         occ_d    = '0;
         player_d = 1'b0;
         err_d    = ERR_NONE;
`ifdef MOVE_COUNT_EN
         cnt_d    = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (move_valid) begin
                  sel_d   = move_sel;
                  state_d = CHECK;
               end
            end
            CHECK: begin
               state_d = RESULT;
               if (onehot == '0) begin
                  reject_d = 1'b1;
                  err_d    = ERR_RANGE;
               end else if ((onehot & occ_q) != '0) begin
                  reject_d = 1'b1;
                  err_d    = ERR_OCC;
               end else begin
                  en_d     = onehot;
                  ack_d    = 1'b1;
                  err_d    = ERR_NONE;
                  occ_d    = occ_q | onehot;
                  player_d = ~player_q;
`ifdef MOVE_COUNT_EN
                  if (cnt_q != CNT_W'(N_CELLS)) cnt_d = cnt_q + 1'b1;
`endif
               end
            end
            RESULT:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      full_d = &occ_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         en_q     <= '0;
         occ_q    <= '0;
         player_q <= 1'b0;
         ack_q    <= 1'b0;
         reject_q <= 1'b0;
         err_q    <= ERR_NONE;
         full_q   <= 1'b0;
`ifdef MOVE_COUNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         en_q     <= en_d;
         occ_q    <= occ_d;
         player_q <= player_d;
         ack_q    <= ack_d;
         reject_q <= reject_d;
         err_q    <= err_d;
         full_q   <= full_d;
`ifdef MOVE_COUNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign move_ready = (state_q == IDLE) && !clear;
   assign en         = en_q;
   assign player     = player_q;
   assign ack        = ack_q;
   assign reject     = reject_q;
   assign err_code   = err_q;
   assign occupied   = occ_q;
   assign board_full = full_q;
`ifdef MOVE_COUNT_EN
   assign move_count = cnt_q;
`endif

endmodule

// File: tb/tb_cell_move_decoder.sv
// Bench for cell_move_decoder: directed table, clear/reset corner cases and a
// randomized run against a simple board model.
module tb_cell_move_decoder;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        move_valid;
   logic [3:0]  move_sel;
   logic        move_ready;
   logic [8:0]  en;
   logic        player, ack, reject, board_full;
   logic [1:0]  err_code;
   logic [8:0]  occupied;

   logic        v16;
   logic [3:0]  s16;
   logic        rdy16, pl16, ack16, rej16, full16;
   logic [15:0] en16, occ16;
   logic [1:0]  err16;
`ifdef MOVE_COUNT_EN
   logic [3:0]  move_count;
   logic [4:0]  move_count16;
`endif

   always #5 clock = ~clock;

   cell_move_decoder #(.N_CELLS(9), .SEL_W(4)) dut (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .move_valid(move_valid), .move_sel(move_sel), .move_ready(move_ready),
      .en(en), .player(player), .ack(ack), .reject(reject), .err_code(err_code),
      .occupied(occupied), .board_full(board_full)
`ifdef MOVE_COUNT_EN
     ,.move_count(move_count)
`endif
   );

   cell_move_decoder #(.N_CELLS(16), .SEL_W(4)) dut16 (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .move_valid(v16), .move_sel(s16), .move_ready(rdy16),
      .en(en16), .player(pl16), .ack(ack16), .reject(rej16), .err_code(err16),
      .occupied(occ16), .board_full(full16)
`ifdef MOVE_COUNT_EN
     ,.move_count(move_count16)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   // Board model: occupancy bits, whose turn, last error, number of accepted moves.
   logic [8:0] m_occ;
   logic       m_player;
   logic [1:0] m_err;
   int         m_cnt;

   typedef struct {
      logic [3:0] sel;
      logic       exp_ack;
      logic [1:0] exp_err;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_occ = '0; m_player = 1'b0; m_err = 2'b00; m_cnt = 0;
   endtask

   task automatic predict(input logic [3:0] sel, output logic a, output logic [1:0] e);
      if (sel >= 4'd9)        begin a = 1'b0; e = 2'b01; end
      else if (m_occ[sel])    begin a = 1'b0; e = 2'b10; end
      else                    begin a = 1'b1; e = 2'b00; end
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_ack"}, ack, 0);
      chk({nm, "_rej"}, reject, 0);
      chk({nm, "_en"}, en, 0);
   endtask

   // Starts and ends at negedge+1 of an IDLE cycle; checks every cycle of one move.
   task automatic do_move(input logic [3:0] sel, input logic ea, input logic [1:0] ee);
      logic [8:0] een;
      @(negedge clock);
      move_valid = 1'b1; move_sel = sel; #1;
      chk("ready_idle", move_ready, 1);
      @(negedge clock);
      move_valid = 1'($urandom); move_sel = 4'($urandom); #1;
      chk("ready_check", move_ready, 0);
      chk_quiet("check");
      een = ea ? (9'd1 << sel) : 9'd0;
      if (ea) begin
         m_occ = m_occ | een; m_player = ~m_player;
         if (m_cnt < 9) m_cnt++;
      end
      m_err = ee;
      @(negedge clock);
      move_valid = 1'($urandom); move_sel = 4'($urandom); #1;
      chk("res_en", en, een);
      chk("res_ack", ack, ea);
      chk("res_rej", reject, !ea);
      chk("res_err", err_code, ee);
      chk("res_occ", occupied, m_occ);
      chk("res_player", player, m_player);
      chk("res_full", board_full, &m_occ);
      chk("ready_res", move_ready, 0);
`ifdef MOVE_COUNT_EN
      chk("res_cnt", move_count, m_cnt);
`endif
      move_valid = 1'b0; #1;
      @(negedge clock); #1;
      chk("ready_back", move_ready, 1);
      chk_quiet("after");
      chk("err_hold", err_code, m_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic       a;
      logic [1:0] e;
      logic [3:0] s;
      reset_n = 1'b0; clear = 1'b0; move_valid = 1'b0; move_sel = '0;
      v16 = 1'b0; s16 = '0;
      model_reset();
      #12;
      @(negedge clock);
      reset_n = 1'b1; #1;
      chk("rst_ready", move_ready, 1);
      chk_quiet("rst");
      chk("rst_occ", occupied, 0);
      chk("rst_player", player, 0);
      chk("rst_err", err_code, 0);
      chk("rst_full", board_full, 0);

      // 16-cell board: top index is legal
      v16 = 1'b1; s16 = 4'd15;
      @(negedge clock); v16 = 1'b0;
      @(negedge clock); #1;
      chk("n16_en", en16, 16'h8000);
      chk("n16_ack", ack16, 1);
      chk("n16_occ", occ16, 16'h8000);
      chk("n16_player", pl16, 1);
      @(negedge clock);

      tbl[0] = '{4'd4,  1'b1, 2'b00};
      tbl[1] = '{4'd4,  1'b0, 2'b10};
      tbl[2] = '{4'd9,  1'b0, 2'b01};
      tbl[3] = '{4'd15, 1'b0, 2'b01};
      foreach (tbl[i]) do_move(tbl[i].sel, tbl[i].exp_ack, tbl[i].exp_err);

      // clear in IDLE together with move_valid: not accepted
      @(negedge clock);
      clear = 1'b1; move_valid = 1'b1; move_sel = 4'd5; #1;
      chk("clr_valid_ready", move_ready, 0);
      @(negedge clock);
      clear = 1'b0; move_valid = 1'b0; #1;
      model_reset();
      chk("clr_ready", move_ready, 1);
      chk("clr_occ", occupied, 0);
      chk("clr_player", player, 0);
      chk("clr_err", err_code, 0);
      @(negedge clock); #1;
      chk_quiet("clr_noaccept");

      // fill the board
      for (int i = 0; i < 9; i++) do_move(4'(i), 1'b1, 2'b00);
      chk("full_after9", board_full, 1);
      do_move(4'd2, 1'b0, 2'b10);
`ifdef MOVE_COUNT_EN
      chk("cnt_sat", move_count, 9);
`endif

      // clear during CHECK aborts the move
      @(negedge clock);
      move_valid = 1'b1; move_sel = 4'd3;
      @(negedge clock);
      move_valid = 1'b0; clear = 1'b1;
      @(negedge clock);
      clear = 1'b0; #1;
      model_reset();
      chk_quiet("abort");
      chk("abort_occ", occupied, 0);
      chk("abort_player", player, 0);
      chk("abort_full", board_full, 0);
      chk("abort_ready", move_ready, 1);
      @(negedge clock); #1;
      chk_quiet("abort_late");

      // clear during RESULT: pulses still appear, state cleared next edge
      move_valid = 1'b1; move_sel = 4'd1;
      @(negedge clock); move_valid = 1'b0;
      @(negedge clock); clear = 1'b1; #1;
      chk("clrres_ack", ack, 1);
      chk("clrres_en", en, 9'h002);
      @(negedge clock); clear = 1'b0; #1;
      chk("clrres_occ", occupied, 0);
      chk("clrres_player", player, 0);
      chk_quiet("clrres_after");

      // async reset mid-CHECK
      do_move(4'd0, 1'b1, 2'b00);
      do_move(4'd0, 1'b0, 2'b10);
      @(negedge clock);
      move_valid = 1'b1; move_sel = 4'd6;
      @(negedge clock);
      move_valid = 1'b0; #2;
      reset_n = 1'b0; #1;
      chk("arst_occ", occupied, 0);
      chk("arst_player", player, 0);
      chk("arst_err", err_code, 0);
      chk("arst_ready", move_ready, 1);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      @(negedge clock); #1;
      chk_quiet("arst_after");

      // randomized moves against the model
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clock); clear = 1'b1;
            @(negedge clock); clear = 1'b0; #1;
            model_reset();
            chk("rnd_clr_occ", occupied, 0);
         end else begin
            s = 4'($urandom_range(0, 15));
            predict(s, a, e);
            do_move(s, a, e);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
